// File: rtl/cache_arbiter_if.sv
// Cache arbiter bus bundle: I-cache port, D-cache port and memory port.
// slave  : arbiter view (serves both caches, drives the memory request).
// master : environment view (caches plus memory model).
interface cache_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic [ADDR_W-1:0] i_addr;
  logic              i_read;
  logic              i_write;
  logic [LINE_W-1:0] i_wdata;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic [ADDR_W-1:0] d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_addr, i_read, i_write, i_wdata,
    output i_rdata, i_resp,
    input  d_addr, d_read, d_write, d_wdata,
    output d_rdata, d_resp,
    output mem_addr, mem_read, mem_write, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_addr, i_read, i_write, i_wdata,
    input  i_rdata, i_resp,
    output d_addr, d_read, d_write, d_wdata,
    input  d_rdata, d_resp,
    input  mem_addr, mem_read, mem_write, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-port (I/D) cache line arbiter in front of a single memory port.
// Optional feature macro CACHE_ARB_RR_EN: round-robin tie-break between I and D.
// Without it, ties always go to D and no last-grant pointer exists.
module cache_arbiter (
  input  logic             clk,
  input  logic             rst,
  cache_arbiter_if.slave   bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
`ifdef CACHE_ARB_RR_EN
  logic              last_d_q, last_d_d;
`endif

  logic i_req, d_req, grant_d;
  logic i_done, d_done;

  assign i_req = bus.i_read | bus.i_write;
  assign d_req = bus.d_read | bus.d_write;

  // Winner select when leaving IDLE; only meaningful when a port requests
`ifdef CACHE_ARB_RR_EN
  assign grant_d = d_req & ~(i_req & last_d_q);
`else
  assign grant_d = d_req;
`endif

  // Next-state, request latch and memory command computation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
`ifdef CACHE_ARB_RR_EN
    last_d_d    = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d     = grant_d ? GRANT_D : GRANT_I;
          addr_d      = grant_d ? bus.d_addr  : bus.i_addr;
          wdata_d     = grant_d ? bus.d_wdata : bus.i_wdata;
          // write wins when a port raises both read and write
          mem_write_d = grant_d ? bus.d_write : bus.i_write;
          mem_read_d  = ~mem_write_d;
`ifdef CACHE_ARB_RR_EN
          last_d_d    = grant_d;
`endif
        end
      end
      GRANT_I, GRANT_D: begin
        if (bus.mem_resp) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched-request registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
`ifdef CACHE_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
`ifdef CACHE_ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  // Completion is passed through in the mem_resp cycle; reset masks a late response
  assign i_done = ~rst & (state_q == GRANT_I) & bus.mem_resp;
  assign d_done = ~rst & (state_q == GRANT_D) & bus.mem_resp;

  assign bus.i_resp  = i_done;
  assign bus.d_resp  = d_done;
  assign bus.i_rdata = i_done ? bus.mem_rdata : {LINE_W{1'b0}};
  assign bus.d_rdata = d_done ? bus.mem_rdata : {LINE_W{1'b0}};

  // Memory side comes only from the latched registers
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
endmodule
